// File: rtl/i2c_stream_sequencer_pkg.sv
// i2c_seq_pkg: shared definitions for the I2C write-stream sequencer.
//   - i2c engine instruction encodings
//   - main sequencer FSM state type
//   - per-operation handshake FSM state type
//   - helper that forms the address byte for a write transfer
package i2c_seq_pkg;

  localparam logic [1:0] INST_START = 2'd0;
  localparam logic [1:0] INST_STOP  = 2'd1;
  localparam logic [1:0] INST_READ  = 2'd2;
  localparam logic [1:0] INST_WRITE = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_TX,
    S_ADDR_TX,
    S_CTRL_TX,
    S_FETCH,
    S_DATA_TX,
    S_STOP_TX,
    S_FINISH
  } seq_state_t;

  typedef enum logic [2:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_WAIT_ACCEPT,
    HS_WAIT_DONE,
    HS_RELEASE
  } hs_state_t;

  // 7-bit device address followed by the R/W bit cleared (write).
  function automatic logic [7:0] addr_write_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_stream_sequencer_handshake.sv
// i2c_op_handshake: runs one i2c engine operation with the 4-phase
// enable/complete protocol and aborts it if it takes too long.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_go            request an operation (accepted in HS_IDLE/HS_RELEASE)
//   i_instr, i_byte instruction and byte, captured when i_go is accepted
//   i_complete      engine done flag
//   o_op_done       pulse: engine reported completion (enable still high)
//   o_op_timeout    pulse: wait exceeded TIMEOUT cycles, operation dropped
//   o_enable        engine operation request
//   o_instr, o_byte instruction/byte held stable while o_enable is high
module i2c_op_handshake
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_go,
  input  logic [1:0] i_instr,
  input  logic [7:0] i_byte,
  input  logic       i_complete,
  output logic       o_op_done,
  output logic       o_op_timeout,
  output logic       o_enable,
  output logic [1:0] o_instr,
  output logic [7:0] o_byte
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  hs_state_t        r_state;
  hs_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_instr;
  logic [7:0]       r_byte;
  logic             w_accept;
  logic             w_waiting;
  logic             w_expired;
  logic             w_timeout;

  // A new request may be taken during RELEASE so back-to-back operations
  // cost only the issue and release cycles.
  assign w_accept  = i_go && ((r_state == HS_IDLE) || (r_state == HS_RELEASE));
  assign w_waiting = (r_state == HS_WAIT_ACCEPT) || (r_state == HS_WAIT_DONE);
  assign w_expired = w_waiting && (r_cnt == CNT_W'(TIMEOUT - 1));
  // A completion arriving on the last allowed cycle still counts as success.
  assign w_timeout = w_expired && !((r_state == HS_WAIT_DONE) && i_complete);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= HS_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HS_IDLE:        if (w_accept) w_next = HS_ISSUE;
      HS_ISSUE:       w_next = HS_WAIT_ACCEPT;
      HS_WAIT_ACCEPT: begin
        if (w_timeout)       w_next = HS_IDLE;
        else if (!i_complete) w_next = HS_WAIT_DONE;
      end
      HS_WAIT_DONE: begin
        if (i_complete)     w_next = HS_RELEASE;
        else if (w_timeout) w_next = HS_IDLE;
      end
      HS_RELEASE:     w_next = w_accept ? HS_ISSUE : HS_IDLE;
      default:        w_next = HS_IDLE;
    endcase
  end

  always_comb begin
    o_enable     = (r_state == HS_ISSUE) || w_waiting;
    o_op_done    = (r_state == HS_WAIT_DONE) && i_complete;
    o_op_timeout = w_timeout;
    o_instr      = r_instr;
    o_byte       = r_byte;
  end

  // The timeout counter spans both wait phases of one operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_instr <= INST_START;
      r_byte  <= '0;
    end else begin
      if (w_accept) begin
        r_instr <= i_instr;
        r_byte  <= i_byte;
      end
      if (w_waiting) r_cnt <= r_cnt + CNT_W'(1);
      else           r_cnt <= '0;
    end
  end

endmodule

// File: rtl/i2c_stream_sequencer.sv
// i2c_stream_sequencer: issues one complete I2C write transaction per start
// pulse: START, {DEV_ADDR,0}, optional CTRL_BYTE, `length` bytes read from a
// synchronous byte memory starting at `base_addr`, STOP.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request (sampled only while idle)
//   base_addr, length first memory address and byte count, latched at start
//   busy, done, error transaction status (done/error are 1-cycle pulses)
//   mem_addr          memory read address; mem_data valid one cycle later
//   i2c_*             engine operation interface
module i2c_stream_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = 7'h3C,
  parameter logic [7:0] CTRL_BYTE = 8'h00,
  parameter bit         SEND_CTRL = 1'b1,
  parameter int         ADDR_W    = 8,
  parameter int         LEN_W     = 8,
  parameter int         TIMEOUT   = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [1:0]        i2c_instruction,
  output logic              i2c_enable,
  output logic [7:0]        i2c_byte_to_send,
  input  logic              i2c_complete
);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_error;
  logic [ADDR_W-1:0] w_ptr_inc;
  logic              w_go;
  logic [1:0]        w_instr;
  logic [7:0]        w_byte;
  logic              w_op_done;
  logic              w_op_timeout;

  assign w_ptr_inc = r_ptr + ADDR_W'(1);

  i2c_op_handshake #(
    .TIMEOUT (TIMEOUT)
  ) u_hs (
    .clk          (clk),
    .rst          (rst),
    .i_go         (w_go),
    .i_instr      (w_instr),
    .i_byte       (w_byte),
    .i_complete   (i2c_complete),
    .o_op_done    (w_op_done),
    .o_op_timeout (w_op_timeout),
    .o_enable     (i2c_enable),
    .o_instr      (i2c_instruction),
    .o_byte       (i2c_byte_to_send)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_op_timeout) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start) w_next = S_START_TX;
        S_START_TX: if (w_op_done) w_next = S_ADDR_TX;
        S_ADDR_TX:  if (w_op_done) w_next = SEND_CTRL ? S_CTRL_TX :
                                            ((r_rem != '0) ? S_FETCH : S_STOP_TX);
        S_CTRL_TX:  if (w_op_done) w_next = (r_rem != '0) ? S_FETCH : S_STOP_TX;
        S_FETCH:    w_next = S_DATA_TX;
        S_DATA_TX:  if (w_op_done) w_next = (r_rem == LEN_W'(1)) ? S_STOP_TX : S_FETCH;
        S_STOP_TX:  if (w_op_done) w_next = S_FINISH;
        S_FINISH:   w_next = S_IDLE;
        default:    w_next = S_IDLE;
      endcase
    end
  end

  // The handshake ignores go while an operation is in flight, and this FSM
  // leaves each *_TX state on op_done, so holding go for the whole state
  // issues exactly one operation per state.
  always_comb begin
    w_go    = 1'b0;
    w_instr = INST_WRITE;
    w_byte  = '0;
    case (r_state)
      S_START_TX: begin w_go = 1'b1; w_instr = INST_START; end
      S_ADDR_TX:  begin w_go = 1'b1; w_byte = addr_write_byte(DEV_ADDR); end
      S_CTRL_TX:  begin w_go = 1'b1; w_byte = CTRL_BYTE; end
      // mem_data is valid in the first DATA_TX cycle, the one where the
      // handshake captures the byte.
      S_DATA_TX:  begin w_go = 1'b1; w_byte = mem_data; end
      S_STOP_TX:  begin w_go = 1'b1; w_instr = INST_STOP; end
      default:    ;
    endcase
    busy     = (r_state != S_IDLE) && (r_state != S_FINISH);
    done     = (r_state == S_FINISH);
    error    = r_error;
    mem_addr = r_mem_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_rem      <= '0;
      r_mem_addr <= '0;
      r_error    <= 1'b0;
    end else begin
      r_error <= w_op_timeout;
      if ((r_state == S_IDLE) && start) begin
        r_ptr <= base_addr;
        r_rem <= length;
      end
      if ((r_state == S_DATA_TX) && w_op_done) begin
        r_ptr <= w_ptr_inc;
        r_rem <= r_rem - LEN_W'(1);
      end
      // Present the read address on entry to FETCH so the byte arrives on
      // the following cycle.
      if ((w_next == S_FETCH) && (r_state != S_FETCH))
        r_mem_addr <= (r_state == S_DATA_TX) ? w_ptr_inc : r_ptr;
    end
  end

endmodule
